// File: rtl/lfsr_checker.sv
// lfsr_checker: serial PRBS checker for the 14-bit Fibonacci LFSR stream
// (feedback s[13]^s[4]^s[2]^s[0]). It fills a local register from the
// stream, hunts for a run of correct predictions, then free-runs the local
// copy and counts mismatches and checked bits while locked.
module lfsr_checker #(
    parameter int LOCK_COUNT = 16,
    parameter int MISS_LIMIT = 4,
    parameter int ERR_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Terminal values of the internal run counters: reaching them on the
    // current bit completes the fill, the lock, or the loss of lock.
    localparam logic [3:0] FILL_LAST  = 4'd13;
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_COUNT - 1);
    localparam logic [3:0] MISS_LAST  = 4'(MISS_LIMIT - 1);

    state_t      state_reg, state_next;
    logic [13:0] s_reg, s_next;
    logic [3:0]  fill_cnt_reg, fill_cnt_next;
    logic [7:0]  match_cnt_reg, match_cnt_next;
    logic [3:0]  miss_cnt_reg, miss_cnt_next;

    logic             locked_reg, locked_next;
    logic             err_pulse_reg, err_pulse_next;
    logic             lock_lost_reg, lock_lost_next;
    logic [ERR_W-1:0] err_count_reg;
    logic [CNT_W-1:0] bit_count_reg;

    logic err_inc;
    logic bit_inc;
    logic pred;

    // Prediction of the next stream bit from the local register.
    assign pred = s_reg[13] ^ s_reg[4] ^ s_reg[2] ^ s_reg[0];

    // Next-state logic: fill/hunt/locked sequencing and per-bit events.
    always_comb begin
        state_next     = state_reg;
        s_next         = s_reg;
        fill_cnt_next  = fill_cnt_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_pulse_next = 1'b0;
        lock_lost_next = 1'b0;
        err_inc        = 1'b0;
        bit_inc        = 1'b0;

        if (bit_valid) begin
            case (state_reg)
                ST_FILL: begin
                    s_next = {s_reg[12:0], bit_in};
                    if (fill_cnt_reg == FILL_LAST) begin
                        state_next     = ST_HUNT;
                        fill_cnt_next  = 4'd0;
                        match_cnt_next = 8'd0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + 4'd1;
                    end
                end
                ST_HUNT: begin
                    s_next = {s_reg[12:0], bit_in};
                    // An all-zero register is a fixed point of the LFSR and
                    // would "predict" a stuck-at-zero line, so it never counts.
                    if ((bit_in == pred) && (s_reg != 14'd0)) begin
                        if (match_cnt_reg == LOCK_LAST) begin
                            state_next     = ST_LOCKED;
                            match_cnt_next = 8'd0;
                            miss_cnt_next  = 4'd0;
                        end else begin
                            match_cnt_next = match_cnt_reg + 8'd1;
                        end
                    end else begin
                        match_cnt_next = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on our own prediction so a single channel
                    // error shows up as exactly one mismatch.
                    s_next  = {s_reg[12:0], pred};
                    bit_inc = 1'b1;
                    if (bit_in != pred) begin
                        err_inc        = 1'b1;
                        err_pulse_next = 1'b1;
                        if (miss_cnt_reg == MISS_LAST) begin
                            state_next     = ST_FILL;
                            fill_cnt_next  = 4'd0;
                            miss_cnt_next  = 4'd0;
                            lock_lost_next = 1'b1;
                        end else begin
                            miss_cnt_next = miss_cnt_reg + 4'd1;
                        end
                    end else begin
                        miss_cnt_next = 4'd0;
                    end
                end
                default: begin
                    state_next    = ST_FILL;
                    fill_cnt_next = 4'd0;
                end
            endcase
        end

        locked_next = (state_next == ST_LOCKED);
    end

    // State, shift register, run counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_FILL;
            s_reg         <= 14'd0;
            fill_cnt_reg  <= 4'd0;
            match_cnt_reg <= 8'd0;
            miss_cnt_reg  <= 4'd0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            s_reg         <= s_next;
            fill_cnt_reg  <= fill_cnt_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    // Saturating statistics counters; clear takes priority over an increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_count_reg <= '0;
            bit_count_reg <= '0;
        end else begin
            if (err_inc && (err_count_reg != {ERR_W{1'b1}})) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
            if (bit_inc && (bit_count_reg != {CNT_W{1'b1}})) begin
                bit_count_reg <= bit_count_reg + 1'b1;
            end
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign lock_lost = lock_lost_reg;
    assign err_count = err_count_reg;
    assign bit_count = bit_count_reg;

endmodule
